// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU control path: opcodes,
// datapath mux encodings, fault codes and the control FSM state enum.
package cpu_defs;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU B-operand mux select
    localparam logic [1:0] SRCB_DATAB = 2'b00;
    localparam logic [1:0] SRCB_CONST = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Sticky fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_WB_MEM   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_WB_R     = 4'd9,
        ST_WB_I     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_FAULT    = 4'd13
    } ctrlStateE;

    // States that hold a memory request open until MemReady
    function automatic logic isMemState(input ctrlStateE s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle in which the
// wait budget is exhausted. MEM_TIMEOUT must be at least 1.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic waitCycle,   // in a memory state with MemReady low
    output logic timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] waitCount;

    // Every memory state is left as soon as MemReady is seen, so clearing on
    // any non-wait cycle restarts the count on each new memory state entry.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            waitCount <= '0;
        end else if (waitCycle) begin
            waitCount <= waitCount + 1'b1;
        end else begin
            waitCount <= '0;
        end
    end

    // This wait cycle is the MEM_TIMEOUT-th one; MemReady high never times out
    assign timeout = waitCycle && (waitCount == LAST_WAIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM. Moore-style decode of datapath strobes from
// the state register, with FETCH PCWrite/IRWrite and MEM_WR Retire qualified
// by MemReady. Memory states that stall too long trap to a sticky FAULT.
//
// Memory handshake: the control path is the requester and MemReady is the
// only response. The request strobes (MemRead/MemWrite) are held in every
// cycle of a memory state; the access completes in the cycle MemReady=1 is
// sampled, and the FSM leaves the memory state on that edge.
module mc_control_fsm
    import cpu_defs::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Retire,
    output logic [1:0] Fault,
    output logic [3:0] stateDbg
);

    ctrlStateE  state;
    ctrlStateE  nextState;
    logic [1:0] faultCode;
    logic [1:0] nextFault;
    logic       waitCycle;
    logic       timeout;

    assign waitCycle = isMemState(state) && !MemReady;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uWaitTimer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .waitCycle (waitCycle),
        .timeout   (timeout)
    );

    // State and sticky fault code registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            faultCode <= FAULT_NONE;
        end else begin
            state     <= nextState;
            faultCode <= nextFault;
        end
    end

    // Next-state logic: instruction sequencing, memory stalls and traps
    always_comb begin
        nextState = state;
        nextFault = faultCode;
        case (state)
            ST_IDLE: nextState = ST_FETCH;
            ST_FETCH: begin
                if (MemReady) begin
                    nextState = ST_DECODE;
                end else if (timeout) begin
                    nextState = ST_FAULT;
                    nextFault = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     nextState = ST_EXEC_R;
                    OP_LW, OP_SW: nextState = ST_MEM_ADDR;
                    OP_ADDI:      nextState = ST_EXEC_I;
                    OP_BEQ:       nextState = ST_BRANCH;
                    OP_J:         nextState = ST_JUMP;
                    default: begin
                        nextState = ST_FAULT;
                        nextFault = FAULT_ILLEGAL;
                    end
                endcase
            end
            // Only LW and SW reach address generation
            ST_MEM_ADDR: nextState = (Opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (MemReady) begin
                    nextState = ST_WB_MEM;
                end else if (timeout) begin
                    nextState = ST_FAULT;
                    nextFault = FAULT_TIMEOUT;
                end
            end
            ST_MEM_WR: begin
                if (MemReady) begin
                    nextState = ST_FETCH;
                end else if (timeout) begin
                    nextState = ST_FAULT;
                    nextFault = FAULT_TIMEOUT;
                end
            end
            ST_EXEC_R: nextState = ST_WB_R;
            ST_EXEC_I: nextState = ST_WB_I;
            ST_WB_MEM, ST_WB_R, ST_WB_I, ST_BRANCH, ST_JUMP: nextState = ST_FETCH;
            ST_FAULT:  nextState = ST_FAULT;
            default:   nextState = ST_IDLE;
        endcase
    end

    // Output decode from the current state; everything idles low
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_DATAB;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        Retire      = 1'b0;
        case (state)
            ST_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = MemReady;
                PCWrite  = MemReady;
                ALUSrcB  = SRCB_CONST;
                ALUOp    = ALUOP_ADD;
                PCSource = PCSRC_ALU;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Retire   = MemReady;
            end
            ST_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                Retire   = 1'b1;
            end
            ST_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_DATAB;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                Retire   = 1'b1;
            end
            ST_WB_I: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_DATAB;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                Retire      = 1'b1;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                Retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign Fault    = faultCode;
    assign stateDbg = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with a 4-cycle memory timeout. Each
// cycle drives MemReady/Opcode, then checks the full output vector and the
// state against hand-written per-state constants.
module tb_mc_control_fsm;
    import cpu_defs::*;

    logic       Clk;
    logic       Rst_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Retire;
    logic [1:0] ALUSrcB, ALUOp, PCSource, Fault;
    logic [3:0] stateDbg;
    logic [18:0] outs;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] R_OP    = 6'b000000;
    localparam logic [5:0] LW_OP   = 6'b100011;
    localparam logic [5:0] SW_OP   = 6'b101011;
    localparam logic [5:0] ADDI_OP = 6'b001000;
    localparam logic [5:0] BEQ_OP  = 6'b000100;
    localparam logic [5:0] J_OP    = 6'b000010;
    localparam logic [5:0] BAD_OP  = 6'b111111;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA},
    // ALUSrcB, ALUOp, PCSource, Retire, Fault
    localparam logic [18:0] E_IDLE    = '0;
    localparam logic [18:0] E_FETCH_W = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_FETCH_R = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_DECODE  = {10'b0000000000, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_MADDR   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_MRD     = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_MWR_W   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_MWR_R   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] E_WBMEM   = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] E_EXR     = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_EXI     = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] E_WBR     = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] E_WBI     = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] E_BR      = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b1, 2'b00};
    localparam logic [18:0] E_JMP     = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b1, 2'b00};
    localparam logic [18:0] E_FLT_ILL = 19'd1;
    localparam logic [18:0] E_FLT_TO  = 19'd2;

    mc_control_fsm #(
        .MEM_TIMEOUT(4)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .Retire      (Retire),
        .Fault       (Fault),
        .stateDbg    (stateDbg)
    );

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, Retire, Fault};

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs and state, then advance past the edge
    task automatic cyc(input logic mr, input logic [5:0] op, input logic [18:0] expOut,
                       input ctrlStateE expSt, input string tag);
        MemReady = mr;
        Opcode   = op;
        #1;
        chk({tag, ".outs"}, 32'(outs), 32'(expOut));
        chk({tag, ".state"}, 32'(stateDbg), 32'(expSt));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n    = 1'b0;
        MemReady = 1'b0;
        Opcode   = R_OP;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst.outs", 32'(outs), 32'(E_IDLE));
        chk("rst.state", 32'(stateDbg), 32'(ST_IDLE));

        // Release reset: one IDLE cycle, then FETCH; IRWrite follows MemReady
        Rst_n = 1'b1;
        cyc(0, R_OP, E_IDLE,    ST_IDLE,   "rel.idle");
        cyc(0, R_OP, E_FETCH_W, ST_FETCH,  "rel.fetch_wait");
        cyc(1, R_OP, E_FETCH_R, ST_FETCH,  "rel.fetch_rdy");
        cyc(1, R_OP, E_DECODE,  ST_DECODE, "r0.decode");
        cyc(1, R_OP, E_EXR,     ST_EXEC_R, "r0.exec");
        cyc(1, R_OP, E_WBR,     ST_WB_R,   "r0.wb");

        // R-type, zero wait: 4 cycles FETCH to FETCH
        cyc(1, R_OP, E_FETCH_R, ST_FETCH,  "r1.fetch");
        cyc(1, R_OP, E_DECODE,  ST_DECODE, "r1.decode");
        cyc(1, R_OP, E_EXR,     ST_EXEC_R, "r1.exec");
        cyc(1, R_OP, E_WBR,     ST_WB_R,   "r1.wb");

        // LW with three MemReady-low cycles in MEM_RD: 8 cycles total
        cyc(1, LW_OP, E_FETCH_R, ST_FETCH,    "lw.fetch");
        cyc(1, LW_OP, E_DECODE,  ST_DECODE,   "lw.decode");
        cyc(1, LW_OP, E_MADDR,   ST_MEM_ADDR, "lw.addr");
        for (int i = 0; i < 3; i++) cyc(0, LW_OP, E_MRD, ST_MEM_RD, "lw.rd_wait");
        cyc(1, LW_OP, E_MRD,     ST_MEM_RD,   "lw.rd_rdy");
        cyc(1, LW_OP, E_WBMEM,   ST_WB_MEM,   "lw.wb");

        // SW, zero wait: 4 cycles, Retire in the ready MEM_WR cycle
        cyc(1, SW_OP, E_FETCH_R, ST_FETCH,    "sw.fetch");
        cyc(1, SW_OP, E_DECODE,  ST_DECODE,   "sw.decode");
        cyc(1, SW_OP, E_MADDR,   ST_MEM_ADDR, "sw.addr");
        cyc(1, SW_OP, E_MWR_R,   ST_MEM_WR,   "sw.wr_rdy");

        // ADDI, BEQ, J
        cyc(1, ADDI_OP, E_FETCH_R, ST_FETCH,  "addi.fetch");
        cyc(1, ADDI_OP, E_DECODE,  ST_DECODE, "addi.decode");
        cyc(1, ADDI_OP, E_EXI,     ST_EXEC_I, "addi.exec");
        cyc(1, ADDI_OP, E_WBI,     ST_WB_I,   "addi.wb");
        cyc(1, BEQ_OP,  E_FETCH_R, ST_FETCH,  "beq.fetch");
        cyc(1, BEQ_OP,  E_DECODE,  ST_DECODE, "beq.decode");
        cyc(1, BEQ_OP,  E_BR,      ST_BRANCH, "beq.branch");
        cyc(1, J_OP,    E_FETCH_R, ST_FETCH,  "j.fetch");
        cyc(1, J_OP,    E_DECODE,  ST_DECODE, "j.decode");
        cyc(1, J_OP,    E_JMP,     ST_JUMP,   "j.jump");

        // SW with MemReady arriving on the 4th MEM_WR cycle: completes, no fault
        cyc(1, SW_OP, E_FETCH_R, ST_FETCH,    "swl.fetch");
        cyc(1, SW_OP, E_DECODE,  ST_DECODE,   "swl.decode");
        cyc(1, SW_OP, E_MADDR,   ST_MEM_ADDR, "swl.addr");
        for (int i = 0; i < 3; i++) cyc(0, SW_OP, E_MWR_W, ST_MEM_WR, "swl.wr_wait");
        cyc(1, SW_OP, E_MWR_R,   ST_MEM_WR,   "swl.wr_rdy");

        // Wait count restarts in FETCH: three waits then ready, then illegal opcode
        for (int i = 0; i < 3; i++) cyc(0, BAD_OP, E_FETCH_W, ST_FETCH, "bad.fetch_wait");
        cyc(1, BAD_OP, E_FETCH_R, ST_FETCH,  "bad.fetch_rdy");
        cyc(1, BAD_OP, E_DECODE,  ST_DECODE, "bad.decode");
        cyc(1, BAD_OP, E_FLT_ILL, ST_FAULT,  "bad.fault0");
        cyc(0, R_OP,   E_FLT_ILL, ST_FAULT,  "bad.fault1");
        cyc(1, J_OP,   E_FLT_ILL, ST_FAULT,  "bad.fault2");

        // Reset out of FAULT clears the fault code
        Rst_n = 1'b0;
        #1;
        chk("frst.outs", 32'(outs), 32'(E_IDLE));
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        cyc(1, SW_OP, E_IDLE,    ST_IDLE,     "ar.idle");
        cyc(1, SW_OP, E_FETCH_R, ST_FETCH,    "ar.fetch");
        cyc(1, SW_OP, E_DECODE,  ST_DECODE,   "ar.decode");
        cyc(1, SW_OP, E_MADDR,   ST_MEM_ADDR, "ar.addr");
        cyc(0, SW_OP, E_MWR_W,   ST_MEM_WR,   "ar.wr_wait");

        // Asynchronous reset mid MEM_WR: MemWrite drops before the next edge
        MemReady = 1'b0;
        #1;
        chk("ar.memwrite_before", 32'(MemWrite), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("ar.outs_async", 32'(outs), 32'(E_IDLE));
        chk("ar.state_async", 32'(stateDbg), 32'(ST_IDLE));
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        cyc(1, SW_OP, E_IDLE,    ST_IDLE,     "to.idle");
        cyc(1, SW_OP, E_FETCH_R, ST_FETCH,    "to.fetch");
        cyc(1, SW_OP, E_DECODE,  ST_DECODE,   "to.decode");
        cyc(1, SW_OP, E_MADDR,   ST_MEM_ADDR, "to.addr");

        // SW with MemReady stuck low: FAULT after 4 wait cycles, sticky
        for (int i = 0; i < 4; i++) cyc(0, SW_OP, E_MWR_W, ST_MEM_WR, "to.wr_wait");
        cyc(0, SW_OP, E_FLT_TO, ST_FAULT, "to.fault0");
        cyc(1, SW_OP, E_FLT_TO, ST_FAULT, "to.fault1");
        cyc(1, R_OP,  E_FLT_TO, ST_FAULT, "to.fault2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
